// File: rtl/topk_sorted_drain_if.sv
// Stream-in / drain-out bus for topk_sorted_drain.
// The producer/host side uses the master modport and the block uses the slave modport.
interface topk_sorted_drain_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
);
  localparam int CW = $clog2(K + 1);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  in_ready;
  logic                  drain;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  out_last;
  logic [CW-1:0]         count;

  modport master (
    output in_valid, din, drain, out_ready,
    input  in_ready, out_valid, dout, out_last, count
  );

  modport slave (
    input  in_valid, din, drain, out_ready,
    output in_ready, out_valid, dout, out_last, count
  );
endinterface

// File: rtl/topk_sorted_drain.sv
// Keeps the K largest distinct unsigned samples as a descending list.
// A drain request reads the list out largest-first over valid/ready, then clears it.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_COLLECT | in_ready=1; accept samples; drain with a non-empty list -> S_DRAIN
// S_DRAIN   | present entry[idx]; advance on transfer; clear after out_last
module topk_sorted_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic clk,
  input  logic resetn,
  topk_sorted_drain_if.slave bus
);
  localparam int CW = $clog2(K + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] entries_q [K];
  logic [DATA_WIDTH-1:0] entries_d [K];
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic                  dup;
  logic [CW-1:0]         pos;
  logic                  ins_ok;
  logic [DATA_WIDTH-1:0] ins_list [K];

  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  out_last;

  // Locate the sample in the sorted list: duplicate check and insert slot.
  // pos counts valid entries strictly greater than din; since the list is
  // descending, that is exactly the slot the sample belongs in.
  always_comb begin
    dup = 1'b0;
    pos = '0;
    for (int i = 0; i < K; i++) begin
      if (CW'(i) < count_q) begin
        if (entries_q[i] == bus.din) dup = 1'b1;
        if (entries_q[i] > bus.din)  pos = pos + CW'(1);
      end
    end
    ins_ok = !dup && (pos < CW'(K));

    ins_list    = entries_q;
    ins_list[0] = (pos == '0) ? bus.din : entries_q[0];
    for (int i = 1; i < K; i++) begin
      if (CW'(i) < pos)       ins_list[i] = entries_q[i];
      else if (CW'(i) == pos) ins_list[i] = bus.din;
      else                    ins_list[i] = entries_q[i-1];
    end
  end

  // Next-state, list update and output decode.
  always_comb begin
    state_d   = state_q;
    entries_d = entries_q;
    count_d   = count_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dout      = '0;
    out_last  = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (bus.in_valid && ins_ok) begin
          entries_d = ins_list;
          count_d   = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
        end
        // Drain sees the list including a same-cycle sample.
        if (bus.drain && (count_d != '0)) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        dout      = entries_q[idx_q];
        out_last  = (CW'(idx_q) == count_q - CW'(1));
        if (bus.out_ready) begin
          if (out_last) begin
            state_d   = S_COLLECT;
            entries_d = '{default: '0};
            count_d   = '0;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State and list registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_COLLECT;
      entries_q <= '{default: '0};
      count_q   <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      entries_q <= entries_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dout      = dout;
  assign bus.out_last  = out_last;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_topk_sorted_drain.sv
// Directed bench for topk_sorted_drain with DATA_WIDTH=8, K=4.
module tb_topk_sorted_drain;
  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  topk_sorted_drain_if #(.DATA_WIDTH(8), .K(4)) bus ();

  topk_sorted_drain #(.DATA_WIDTH(8), .K(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.din      = v;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Pulse drain (optionally with a same-cycle sample), hold out_ready high
  // and expect n entries packed MSB-first in exp.
  task automatic drain_expect(input string tag, input bit with_in, input logic [7:0] v,
                              input logic [31:0] exp, input int n);
    logic [31:0] e;
    e = exp;
    bus.out_ready = 1'b1;
    bus.drain     = 1'b1;
    bus.in_valid  = with_in;
    bus.din       = v;
    step();
    bus.drain    = 1'b0;
    bus.in_valid = 1'b0;
    for (int j = 0; j < n; j++) begin
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_dout"},  bus.dout, e[31:24]);
      check({tag, "_last"},  bus.out_last, (j == n - 1) ? 1 : 0);
      check({tag, "_inrdy"}, bus.in_ready, 0);
      e = e << 8;
      step();
    end
    check({tag, "_end_valid"}, bus.out_valid, 0);
    check({tag, "_end_count"}, bus.count, 0);
    check({tag, "_end_inrdy"}, bus.in_ready, 1);
    check({tag, "_end_dout"},  bus.dout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.din       = '0;
    bus.drain     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("rst_inrdy", bus.in_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    check("rst_dout",  bus.dout, 0);
    check("rst_last",  bus.out_last, 0);
    resetn = 1'b1;
    step();

    // 1: duplicates and the undersized tail sample are dropped
    send(5); send(9); send(3); send(9); send(7); send(1);
    check("t1_count", bus.count, 4);
    drain_expect("t1", 0, 0, {8'd9, 8'd7, 8'd5, 8'd3}, 4);

    // 2: smallest entry falls out when full; small late sample discarded
    send(10); send(20); send(30); send(40); send(50);
    check("t2_count5", bus.count, 4);
    send(15);
    check("t2_count6", bus.count, 4);
    drain_expect("t2", 0, 0, {8'd50, 8'd40, 8'd30, 8'd20}, 4);

    // 3: drain on empty list is ignored
    bus.drain = 1'b1;
    step();
    bus.drain = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("t3_empty_valid", bus.out_valid, 0);
      check("t3_empty_inrdy", bus.in_ready, 1);
      step();
    end
    send(8);
    check("t3_count", bus.count, 1);
    drain_expect("t3", 0, 0, {8'd8, 24'd0}, 1);

    // 4: stalls hold dout; samples during DRAIN are ignored
    send(4); send(2);
    bus.out_ready = 1'b0;
    bus.drain     = 1'b1;
    step();
    bus.drain    = 1'b0;
    bus.in_valid = 1'b1;
    bus.din      = 8'd99;
    check("t4_c0_dout", bus.dout, 4);
    check("t4_c0_last", bus.out_last, 0);
    check("t4_c0_inrdy", bus.in_ready, 0);
    bus.out_ready = 1'b0; step();
    check("t4_c1_dout", bus.dout, 4);
    check("t4_c1_valid", bus.out_valid, 1);
    bus.out_ready = 1'b0; step();
    check("t4_c2_dout", bus.dout, 4);
    bus.drain = 1'b1;
    bus.out_ready = 1'b1; step();
    bus.drain = 1'b0;
    check("t4_c3_dout", bus.dout, 2);
    check("t4_c3_last", bus.out_last, 1);
    bus.out_ready = 1'b0; step();
    check("t4_c4_dout", bus.dout, 2);
    check("t4_c4_last", bus.out_last, 1);
    bus.out_ready = 1'b1; step();
    bus.in_valid = 1'b0;
    check("t4_c5_valid", bus.out_valid, 0);
    check("t4_c5_count", bus.count, 0);
    check("t4_c5_inrdy", bus.in_ready, 1);
    send(6);
    drain_expect("t4b", 0, 0, {8'd6, 24'd0}, 1);

    // 5: sample in the drain cycle is part of the readout
    send(3);
    drain_expect("t5", 1, 8'd77, {8'd77, 8'd3, 16'd0}, 2);

    // 6: reset in the middle of a readout
    send(1); send(2); send(3);
    bus.out_ready = 1'b1;
    bus.drain     = 1'b1;
    step();
    bus.drain = 1'b0;
    check("t6_first", bus.dout, 3);
    step();
    check("t6_second", bus.dout, 2);
    resetn = 1'b0;
    #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_count", bus.count, 0);
    check("t6_rst_inrdy", bus.in_ready, 1);
    step();
    resetn = 1'b1;
    bus.drain = 1'b1;
    step();
    bus.drain = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("t6_after_valid", bus.out_valid, 0);
      step();
    end

    // 7: zero is a legal entry while the list is not full
    send(0); send(5);
    check("t7_count", bus.count, 2);
    drain_expect("t7", 0, 0, {8'd5, 8'd0, 16'd0}, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
